// File: rtl/mips_mem_host_pkg.sv
// Shared definitions for the MIPS memory host: controller states and the
// instruction word returned whenever no valid fetch is possible.
package mips_mem_host_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_word_ram.sv
// Word-wide RAM with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module mips_word_ram #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_host.sv
// Program loader and memory host for a single-cycle MIPS core: streams a program
// into imem while holding the core in reset, then serves fetches and data accesses.
module mips_mem_host
  import mips_mem_host_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [31:0]                   load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic                          core_reset,
  input  logic [31:0]                   pc,
  output logic [31:0]                   instr,
  input  logic [31:0]                   aluOut,
  input  logic [31:0]                   writeData,
  input  logic                          memWrite,
  output logic [31:0]                   readData,
  output logic [$clog2(IMEM_WORDS):0]   load_count,
  output logic                          align_err
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam int CW  = IAW + 1;
  localparam logic [CW-1:0] FULL = CW'(IMEM_WORDS);

  state_t      state;
  logic        xfer;
  logic        full;
  logic        fetch_ok;
  logic        d_in_range;
  logic        misaligned;
  logic        store_en;
  logic [31:0] fetch_limit;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_rdata;

  assign full       = (load_count == FULL);
  assign load_ready = (state == LOAD) && !full;
  assign xfer       = load_valid && load_ready;
  assign core_reset = (state != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      load_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (xfer) begin
            load_count <= load_count + 1'b1;
            if (load_last || (load_count == FULL - 1'b1)) state <= RELEASE;
          end
        end
        RELEASE: state <= RUN;
        RUN:     state <= RUN;
        default: state <= LOAD;
      endcase
    end
  end

  // Only words actually loaded are fetchable; everything beyond reads as a nop.
  assign fetch_limit = {{(32-CW-2){1'b0}}, load_count, 2'b00};
  assign fetch_ok    = (state == RUN) && (pc < fetch_limit);
  assign instr       = fetch_ok ? imem_rdata : NOP;

  assign d_in_range = (aluOut[31:DAW+2] == '0);
  assign misaligned = (aluOut[1:0] != 2'b00);
  assign store_en   = (state == RUN) && memWrite && !misaligned && d_in_range;
  assign readData   = d_in_range ? dmem_rdata : NOP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      align_err <= 1'b0;
    else if ((state == RUN) && memWrite && misaligned) align_err <= 1'b1;
  end

  mips_word_ram #(.DEPTH(IMEM_WORDS)) u_imem (
    .clk   (clk),
    .we    (xfer),
    .waddr (load_count[IAW-1:0]),
    .wdata (load_data),
    .raddr (pc[IAW+1:2]),
    .rdata (imem_rdata)
  );

  mips_word_ram #(.DEPTH(DMEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (store_en),
    .waddr (aluOut[DAW+1:2]),
    .wdata (writeData),
    .raddr (aluOut[DAW+1:2]),
    .rdata (dmem_rdata)
  );

endmodule

// File: tb/tb_mips_mem_host.sv
// Randomised self-checking bench for mips_mem_host: a behavioural model of the
// loader/memories is compared every cycle, plus fixed program/store scenarios.
module tb_mips_mem_host;

  localparam int IW = 64;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        core_reset;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic [31:0] aluOut = '0;
  logic [31:0] writeData = '0;
  logic        memWrite = 1'b0;
  logic [31:0] readData;
  logic [6:0]  load_count;
  logic        align_err;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  mips_mem_host #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .core_reset (core_reset),
    .pc         (pc),
    .instr      (instr),
    .aluOut     (aluOut),
    .writeData  (writeData),
    .memWrite   (memWrite),
    .readData   (readData),
    .load_count (load_count),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = loading, 1 = one-cycle handover, 2 = core running.
  int          m_phase = 0;
  int          m_count = 0;
  bit          m_align = 1'b0;
  logic [31:0] m_imem [IW];
  logic [31:0] m_dmem [DW];
  bit          m_dvalid [DW];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_count = 0;
      m_align = 1'b0;
    end else if (m_phase == 0) begin
      if (load_valid && m_count < IW) begin
        m_imem[m_count] = load_data;
        m_count++;
        if (load_last || m_count == IW) m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (memWrite) begin
      if (aluOut % 4 != 0) m_align = 1'b1;
      else if (aluOut < 4 * DW) begin
        m_dmem[aluOut / 4]   = writeData;
        m_dvalid[aluOut / 4] = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("load_count", 32'(load_count), 32'(m_count));
      checkOutput("core_reset", 32'(core_reset), 32'(m_phase != 2));
      checkOutput("align_err", 32'(align_err), 32'(m_align));
      if (reset) begin
        checkOutput("load_ready", 32'(load_ready), 32'(m_phase == 0 && m_count < IW));
        if (m_phase == 2 && pc < 4 * m_count)
          checkOutput("instr", instr, m_imem[pc / 4]);
        else
          checkOutput("instr_nop", instr, 32'h0);
        if (aluOut >= 4 * DW)
          checkOutput("readData_oor", readData, 32'h0);
        else if (m_dvalid[aluOut / 4])
          checkOutput("readData", readData, m_dmem[aluOut / 4]);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic l,
                               input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] w, input logic mw);
    load_valid = v;
    load_data  = d;
    load_last  = l;
    pc         = p;
    aluOut     = a;
    writeData  = w;
    memWrite   = mw;
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic probe(input logic [31:0] p, input logic [31:0] a);
    load_valid = 1'b0;
    memWrite   = 1'b0;
    pc         = p;
    aluOut     = a;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    idleStep();
    idleStep();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] randAddr();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel <= 4)      randAddr = 32'($urandom_range(0, DW - 1)) << 2;
    else if (sel == 5) randAddr = (32'($urandom_range(0, DW - 1)) << 2) | 32'($urandom_range(1, 3));
    else if (sel == 6) randAddr = 32'(4 * DW) + (32'($urandom_range(0, 15)) << 2);
    else               randAddr = $urandom | 32'h8000_0000;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    checking = 1'b1;

    probe(32'h0, 32'h0);
    checkOutput("rst_load_count", 32'(load_count), 32'd0);
    checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
    checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
    checkOutput("rst_align_err", 32'(align_err), 32'd0);

    // Three-word program, last flagged on the third word.
    applyStimulus(1'b1, 32'h2002_0001, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h2003_0002, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0800_0003, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    probe(32'h0, 32'h0);
    checkOutput("prog3_count", 32'(load_count), 32'd3);
    checkOutput("prog3_release_core_reset", 32'(core_reset), 32'd1);
    checkOutput("prog3_release_ready", 32'(load_ready), 32'd0);
    idleStep();
    probe(32'h0, 32'h0);
    checkOutput("prog3_run_core_reset", 32'(core_reset), 32'd0);
    checkOutput("prog3_pc0", instr, 32'h2002_0001);
    probe(32'h4, 32'h0);
    checkOutput("prog3_pc4", instr, 32'h2003_0002);
    probe(32'h8, 32'h0);
    checkOutput("prog3_pc8", instr, 32'h0800_0003);
    probe(32'hC, 32'h0);
    checkOutput("prog3_pc12", instr, 32'h0);

    // Aligned store then read-back.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    probe(32'h0, 32'h10);
    checkOutput("store_readback", readData, 32'hDEAD_BEEF);
    checkOutput("store_align_ok", 32'(align_err), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b1);

    // Misaligned store is suppressed and flags sticky align_err.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h12, 32'hCAFE_F00D, 1'b1);
    probe(32'h0, 32'h10);
    checkOutput("misalign_unchanged", readData, 32'hDEAD_BEEF);
    checkOutput("misalign_flag", 32'(align_err), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h20, 32'h1234_5678, 1'b1);
    probe(32'h0, 32'h20);
    checkOutput("misalign_sticky", 32'(align_err), 32'd1);
    checkOutput("later_store", readData, 32'h1234_5678);
    probe(32'h0, 32'h104);
    checkOutput("oor_read", readData, 32'h0);

    // Stores attempted while loading must not reach dmem.
    doReset();
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b1, 32'h0, 32'h0, 32'hBAD0_BAD0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'hBAD0_BAD0, 1'b1);
    probe(32'h0, 32'h0);
    checkOutput("load_store_blocked", readData, 32'h1111_1111);
    checkOutput("load_store_instr", instr, 32'hAAAA_0001);
    checkOutput("reset_clears_align", 32'(align_err), 32'd0);

    // Reset aborts a partial load; the reload restarts from slot 0.
    doReset();
    applyStimulus(1'b1, 32'h1111_AAAA, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h2222_BBBB, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    doReset();
    applyStimulus(1'b1, 32'h3C01_0055, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    idleStep();
    probe(32'h0, 32'h0);
    checkOutput("reload_count", 32'(load_count), 32'd1);
    checkOutput("reload_pc0", instr, 32'h3C01_0055);
    probe(32'h4, 32'h0);
    checkOutput("reload_pc4", instr, 32'h0);

    // Fill imem completely without load_last.
    doReset();
    for (int i = 0; i < IW; i++)
      applyStimulus(1'b1, $urandom, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    probe(32'h0, 32'h0);
    checkOutput("full_count", 32'(load_count), 32'd64);
    checkOutput("full_ready", 32'(load_ready), 32'd0);
    applyStimulus(1'b1, $urandom, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    probe(32'hFC, 32'h0);
    checkOutput("full_count_hold", 32'(load_count), 32'd64);
    checkOutput("full_run", 32'(core_reset), 32'd0);

    // Random load/run rounds checked by the model.
    for (int r = 0; r < 6; r++) begin
      doReset();
      for (int i = 0; i < 400 && core_reset; i++)
        applyStimulus(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 9) == 0),
                      $urandom, randAddr(), $urandom, 1'($urandom_range(0, 1)));
      checkOutput("rand_load_done", 32'(core_reset), 32'd0);
      for (int i = 0; i < 150; i++)
        applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 4 * IW + 16)), randAddr(), $urandom,
                      1'($urandom_range(0, 1)));
    end

    idleStep();
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_host.md
MIPS_MEM_HOST -- requirements
Module: mips_mem_host

Interface
REQ-001 Parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter DMEM_WORDS, default 64, data memory depth in 32-bit words (power of two).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low block reset.
REQ-005 load_valid  input  1  loader offers load_data this cycle.
REQ-006 load_data  input  32  instruction word to store at next imem slot.
REQ-007 load_last  input  1  qualifies load_data as final program word.
REQ-008 load_ready  output  1  block accepts a word; a transfer occurs when load_valid and load_ready are both high.
REQ-009 core_reset  output  1  active-high reset driven to the core.
REQ-010 pc  input  32  core fetch address (byte address).
REQ-011 instr  output  32  fetched instruction.
REQ-012 aluOut  input  32  core data byte address.
REQ-013 writeData  input  32  core store data.
REQ-014 memWrite  input  1  core store strobe.
REQ-015 readData  output  32  load data returned to the core.
REQ-016 load_count  output  $clog2(IMEM_WORDS)+1  number of words loaded.
REQ-017 align_err  output  1  sticky flag for a misaligned store.

Function
REQ-018 The FSM SHALL have exactly three states: LOAD, RELEASE and RUN.
REQ-019 LOAD: load_ready=1 and core_reset=1; each transfer writes imem[load_count] and increments load_count.
REQ-020 LOAD -> RELEASE on a transfer with load_last=1, or on the transfer that makes load_count equal IMEM_WORDS, whichever comes first.
REQ-021 In RELEASE, load_ready=0 and core_reset=1 for exactly one cycle; RELEASE -> RUN unconditionally.
REQ-022 RUN: load_ready=0 and core_reset=0; load_valid is ignored; RUN persists until reset.
REQ-023 With load_count at IMEM_WORDS, load_ready SHALL be 0 and load_count SHALL NOT wrap.
REQ-024 instr SHALL equal imem[pc[log2(IMEM_WORDS)+1:2]] combinationally in RUN when pc < 4*load_count; otherwise it SHALL be 32'h00000000 (nop).
REQ-025 instr SHALL be 32'h00000000 in LOAD and RELEASE.
REQ-026 readData SHALL equal dmem[aluOut[log2(DMEM_WORDS)+1:2]] combinationally; out-of-range aluOut SHALL return 0.
REQ-027 A store SHALL write dmem on the rising edge only when state is RUN, memWrite=1, aluOut[1:0]=0 and the address is in range; a read in the following cycle returns the new value.
REQ-028 A store with memWrite=1 and aluOut[1:0]!=0 in RUN SHALL be suppressed and SHALL set align_err, which holds until reset.
REQ-029 An out-of-range aligned store SHALL be dropped silently without setting align_err.

Reset
REQ-030 Asserting reset SHALL immediately force: state LOAD, load_count 0, align_err 0, core_reset 1, load_ready 1 after deassertion.
REQ-031 Reset mid-load or mid-run SHALL abort the operation; the next load overwrites imem from slot 0.
REQ-032 imem and dmem contents SHALL NOT be reset.

Structure
REQ-033 A shared package SHALL hold the state enum (LOAD/RELEASE/RUN) and the NOP constant 32'h00000000.
REQ-034 One sub-module, mips_word_ram (parameterised depth, one sync write port, one async read port), SHALL be instantiated twice, for imem and dmem.

Verification
REQ-035 Load 3 words 20020001, 20030002, 08000003 (last on third) -> load_count=3, one RELEASE cycle, then core_reset=0; pc=0/4/8 return those words and pc=12 returns 0.
REQ-036 Load with load_valid held for IMEM_WORDS+2 cycles and load_last never set -> load_count stops at 64, load_ready drops after the 64th transfer, and RUN is entered.
REQ-037 In RUN, store aluOut=0x10, writeData=0xDEADBEEF -> readData=0xDEADBEEF at aluOut=0x10 on the next cycle; align_err stays 0.
REQ-038 In RUN, store aluOut=0x12 -> dmem word 4 is unchanged, and align_err=1 persists through later stores.
REQ-039 Assert reset after 2 of 3 load transfers, then reload 1 word with load_last -> load_count=1, and pc=0 returns the new word.
REQ-040 memWrite=1 during LOAD with aluOut=0x0 -> dmem is unchanged after entering RUN.
